// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MDOp codes and FSM states.
// The stall controller imports this package to recognise MD-class instructions.
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_BUSY = 2'd1,
        DIV_BUSY  = 2'd2
    } md_state_e;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_busy_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the E stage.
// Results are computed on the start edge and held back until the fixed latency expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic              op_signed;
    logic signed [63:0] a_ext, b_ext;
    logic signed [63:0] prod;
    logic [31:0]       a_mag, b_mag;
    logic [31:0]       q_mag, r_mag;
    logic [31:0]       quot, rem;

    // One multiplier and one divider serve both signed and unsigned forms.
    always_comb begin
        op_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
        a_ext     = op_signed ? signed'({{32{A[31]}}, A}) : signed'({32'd0, A});
        b_ext     = op_signed ? signed'({{32{B[31]}}, B}) : signed'({32'd0, B});
        prod      = a_ext * b_ext;

        // Sign-magnitude divide: 0x80000000 / -1 lands on 0x80000000 with no overflow trap.
        a_mag = (op_signed && A[31]) ? (32'd0 - A) : A;
        b_mag = (op_signed && B[31]) ? (32'd0 - B) : B;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (op_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (op_signed && A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start && ((MDOp == MD_MULT) || (MDOp == MD_MULTU))) begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    state_d   = MULT_BUSY;
                end else if (start && ((MDOp == MD_DIV) || (MDOp == MD_DIVU))) begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    state_d   = DIV_BUSY;
                end else if (MDOp == MD_MTHI) begin
                    hi_d = A;
                end else if (MDOp == MD_MTLO) begin
                    lo_d = A;
                end
            end
            MULT_BUSY, DIV_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized bench for md_unit against an edge-scheduled arithmetic model.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: edge index, edge at which the pending result lands, and architectural HI/LO.
    int          edge_n    = 0;
    int          done_edge = -1;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] p_hi = '0, p_lo = '0;
    bit          p_ok = 1'b0;

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(mdop),
        .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the architectural rules for the inputs presented before edge e.
    task automatic model_edge(input int e);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if ((e - 1) < done_edge) begin
            if (e == done_edge && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            return;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (mdop)
            MD_MULT: if (start) begin
                sq = sa * sb;
                p_hi = sq[63:32]; p_lo = sq[31:0]; p_ok = 1'b1; done_edge = e + NM;
            end
            MD_MULTU: if (start) begin
                uq = ua * ub;
                p_hi = uq[63:32]; p_lo = uq[31:0]; p_ok = 1'b1; done_edge = e + NM;
            end
            MD_DIV: if (start) begin
                p_ok = (b != 32'd0);
                if (p_ok) begin
                    sq = sa / sb; sr = sa % sb;
                    p_hi = sr[31:0]; p_lo = sq[31:0];
                end
                done_edge = e + ND;
            end
            MD_DIVU: if (start) begin
                p_ok = (b != 32'd0);
                if (p_ok) begin
                    uq = ua / ub; ur = ua % ub;
                    p_hi = ur[31:0]; p_lo = uq[31:0];
                end
                done_edge = e + ND;
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic tick();
        int e;
        e = edge_n + 1;
        model_edge(e);
        @(posedge clk);
        #1;
        edge_n = e;
        check("busy", {31'd0, busy}, {31'd0, (e < done_edge)});
        check("HI", hi, m_hi);
        check("LO", lo, m_lo);
    endtask

    task automatic issue(input logic [2:0] op, input logic st, input logic [31:0] av, input logic [31:0] bv);
        mdop = op; start = st; a = av; b = bv;
        tick();
        mdop = MD_NONE; start = 1'b0;
    endtask

    task automatic drain();
        while (edge_n < done_edge) tick();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; mdop = MD_NONE; a = '0; b = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // 1: signed multiply
        issue(MD_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
        drain();
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFFA);

        // 2: unsigned multiply
        issue(MD_MULTU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("t2_hi", hi, 32'hFFFF_FFFE);
        check("t2_lo", lo, 32'h0000_0001);

        // 3: signed and unsigned divide of -7 by 2
        issue(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        drain();
        check("t3_lo", lo, 32'hFFFF_FFFD);
        check("t3_hi", hi, 32'hFFFF_FFFF);
        issue(MD_DIVU, 1'b1, 32'hFFFF_FFF9, 32'd2);
        drain();
        check("t3u_lo", lo, 32'h7FFF_FFFC);
        check("t3u_hi", hi, 32'h0000_0001);

        // 4: MTHI then divide by zero
        issue(MD_MTHI, 1'b0, 32'h1234_5678, 32'd0);
        check("t4_hi", hi, 32'h1234_5678);
        issue(MD_MTLO, 1'b1, 32'hCAFE_F00D, 32'd5);
        check("t4_lo", lo, 32'hCAFE_F00D);
        issue(MD_DIV, 1'b1, 32'd99, 32'd0);
        drain();
        check("t4_dz_hi", hi, 32'h1234_5678);
        check("t4_dz_lo", lo, 32'hCAFE_F00D);

        // Overflow case of signed divide
        issue(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);
        issue(MD_MTHI, 1'b0, 32'h0BAD_BEEF, 32'd0);

        // 5: asynchronous reset during a divide
        issue(MD_DIV, 1'b1, 32'd1000, 32'd7);
        tick(); tick(); tick();
        #1 reset = 1'b1;
        #1;
        done_edge = -1; p_ok = 1'b0; m_hi = '0; m_lo = '0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd0);
        #1 reset = 1'b0;
        issue(MD_MULT, 1'b1, 32'd6, 32'hFFFF_FFF9);
        drain();
        check("t5_lo_mult", lo, 32'hFFFF_FFD6);

        // 6: start while busy is ignored; restart right after busy falls is accepted
        issue(MD_MULT, 1'b1, 32'd7, 32'd9);
        issue(MD_DIV, 1'b1, 32'd100, 32'd3);
        issue(MD_MTLO, 1'b0, 32'hDEAD_0000, 32'd0);
        drain();
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd63);
        issue(MD_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000);
        drain();
        check("t6b_hi", hi, 32'd1);
        check("t6b_lo", lo, 32'd0);

        // Randomized operations against the model
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 6)), 1'($urandom_range(0, 3) != 0), rand_operand(), rand_operand());
            drain();
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
